// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// digit encoding, window recoding, FSM states and sizing helpers.
package booth_pkg;

   // One radix-4 Booth digit, range -2..+2
   typedef logic signed [2:0] digit_t;

   localparam digit_t DIG_ZERO = 3'sd0;
   localparam digit_t DIG_POS1 = 3'sd1;
   localparam digit_t DIG_POS2 = 3'sd2;
   localparam digit_t DIG_NEG1 = -3'sd1;
   localparam digit_t DIG_NEG2 = -3'sd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

   // Window is {w[2j+1], w[2j], w[2j-1]}; digit = -2*w[2j+1] + w[2j] + w[2j-1]
   function automatic digit_t booth_recode(input logic [2:0] win);
      case (win)
         3'b001, 3'b010: return DIG_POS1;
         3'b011:         return DIG_POS2;
         3'b100:         return DIG_NEG2;
         3'b101, 3'b110: return DIG_NEG1;
         default:        return DIG_ZERO;
      endcase
   endfunction

   function automatic int calc_num_digits(input int width_data);
      return width_data / 2 + 1;
   endfunction

   function automatic int calc_num_cyc(input int width_data, input int pp_per_cycle);
      return (calc_num_digits(width_data) + pp_per_cycle - 1) / pp_per_cycle;
   endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// One Booth partial product: digit * feature_ext, shifted left by 2*shift_idx,
// sign-extended to the full accumulator width. Purely combinational.
module booth_digit_pp import booth_pkg::*; #(
   parameter int WIDTH_DATA = 8,
   parameter int IDX_W      = 3
) (
   input  logic [2:0]              digit,
   input  logic [WIDTH_DATA:0]     feature_ext,
   input  logic [IDX_W-1:0]        shift_idx,
   output logic [2*WIDTH_DATA+3:0] pp
);

   localparam int ACC_W = 2*WIDTH_DATA + 4;

   digit_t           dig;
   logic             neg;
   logic             dbl;
   logic [ACC_W-1:0] fe_sx;
   logic [ACC_W-1:0] mag;
   logic [ACC_W-1:0] shifted;

   assign dig = digit_t'(digit);

   // Build |d|*feature, place it at weight 4^j, then negate in full width when d < 0
   always_comb begin
      neg   = dig[2];
      dbl   = (dig == DIG_POS2) || (dig == DIG_NEG2);
      fe_sx = {{(ACC_W-WIDTH_DATA-1){feature_ext[WIDTH_DATA]}}, feature_ext};
      if (dig == DIG_ZERO)
         mag = '0;
      else if (dbl)
         mag = fe_sx << 1;
      else
         mag = fe_sx;
      shifted = mag << {shift_idx, 1'b0};
      pp      = neg ? (~shifted + ACC_W'(1)) : shifted;
   end

endmodule

// File: rtl/booth_mult_iter.sv
// Multi-cycle radix-4 Booth multiplier with valid/ready on both sides.
// The weight operand is recoded into Booth digits, PP_PER_CYCLE of them are
// retired per CALC cycle, and one final CALC cycle folds the accumulator into
// the registered product before DONE.
// Optional build macro BOOTH_ACC_EN: adds acc_clr and makes product a running
// sum of results (cleared per transaction by acc_clr, and by reset).
module booth_mult_iter import booth_pkg::*; #(
   parameter int WIDTH_DATA   = 8,
   parameter int PP_PER_CYCLE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH_DATA-1:0]   weight,
   input  logic [WIDTH_DATA-1:0]   feature,
   input  logic                    is_signed,
`ifdef BOOTH_ACC_EN
   input  logic                    acc_clr,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*WIDTH_DATA-1:0] product
);

   localparam int NUM_DIGITS = calc_num_digits(WIDTH_DATA);
   localparam int NUM_CYC    = calc_num_cyc(WIDTH_DATA, PP_PER_CYCLE);
   localparam int ACC_W      = 2*WIDTH_DATA + 4;
   localparam int PROD_W     = 2*WIDTH_DATA;
   localparam int WREG_W     = WIDTH_DATA + 3;
   localparam int IDX_W      = $clog2(NUM_CYC*PP_PER_CYCLE + 1);

   state_t            state;
   logic [WREG_W-1:0] wreg;
   logic [WIDTH_DATA:0] fext;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [IDX_W-1:0]  digit_base;
   logic              calc_last;
   logic              w_sx;
   logic              f_sx;
   logic              acc_unused;
   logic [ACC_W-1:0]  pp_vec [PP_PER_CYCLE];
`ifdef BOOTH_ACC_EN
   logic              acc_clr_q;
`endif

   assign w_sx       = is_signed & weight[WIDTH_DATA-1];
   assign f_sx       = is_signed & feature[WIDTH_DATA-1];
   assign calc_last  = (digit_base >= IDX_W'(NUM_DIGITS));
   assign acc_unused = ^acc[ACC_W-1:PROD_W];

   // wreg is shifted right every retire cycle, so digit k of this cycle always
   // sits in window [2k+2:2k]; digits past NUM_DIGITS are padding and forced to 0
   for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_pp
      digit_t dig;
      assign dig = ((int'(digit_base) + k) < NUM_DIGITS) ? booth_recode(wreg[2*k+2 -: 3])
                                                        : DIG_ZERO;
      booth_digit_pp #(
         .WIDTH_DATA (WIDTH_DATA),
         .IDX_W      (IDX_W)
      ) u_pp (
         .digit       (dig),
         .feature_ext (fext),
         .shift_idx   (digit_base + IDX_W'(k)),
         .pp          (pp_vec[k])
      );
   end

   // Sum this cycle's partial products into the running accumulator
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < PP_PER_CYCLE; k++)
         acc_next = acc_next + pp_vec[k];
   end

   // Control FSM: capture in IDLE, retire digits in CALC, hold the result in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         product    <= '0;
         acc        <= '0;
         digit_base <= '0;
         wreg       <= '0;
         fext       <= '0;
`ifdef BOOTH_ACC_EN
         acc_clr_q  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  wreg       <= {{2{w_sx}}, weight, 1'b0};
                  fext       <= {f_sx, feature};
                  acc        <= '0;
                  digit_base <= '0;
                  in_ready   <= 1'b0;
                  state      <= ST_CALC;
`ifdef BOOTH_ACC_EN
                  acc_clr_q  <= acc_clr;
`endif
               end
            end
            ST_CALC: begin
               if (calc_last) begin
`ifdef BOOTH_ACC_EN
                  product <= (acc_clr_q ? '0 : product) + acc[PROD_W-1:0];
`else
                  product <= acc[PROD_W-1:0];
`endif
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  acc        <= acc_next;
                  wreg       <= wreg >> (2*PP_PER_CYCLE);
                  digit_base <= digit_base + IDX_W'(PP_PER_CYCLE);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
